priority_decoder_hold: RTL
==========================

# priority_decoder_hold

Registered 3-to-8 one-hot decoder with pulse stretching and sticky event capture: the receiving end of the priority encoder's index/valid interface. Each accepted index drives exactly one of eight output lines for a programmable number of cycles, so short encoder events are visible on LEDs or usable by slower logic. An 8-bit sticky pending register records every index seen until software or a button clears it. An event counter counts accepted events and saturates.

## Interface
- HOLD_CYCLES, default 4: number of cycles each decoded line stays high after a single event (legal range 1..255).
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- SEL  input  3  index to decode (priority encoder Y).
- VALID  input  1  SEL is meaningful this cycle (priority encoder VALID).
- CLR  input  1  clears PENDING and EVT_CNT (one-cycle strobe or level).
- D  output  8  one-hot decoded line, registered; all zero when idle.
- ACTIVE  output  1  high while D is non-zero.
- PENDING  output  8  sticky OR of every decoded index since the last CLR or reset.
- EVT_CNT  output  8  number of accepted VALID cycles, saturates at 255.

## Operation
- Reset (RESET_N=0 at an edge): D=0, ACTIVE=0, PENDING=0, EVT_CNT=0, hold counter=0, state=IDLE. Reset overrides every other input, including reset asserted mid-hold.
- A VALID=1 sample at an edge is accepted in every state. SEL is ignored when VALID=0.
- IDLE:
  - If VALID: D<=1<<SEL, ACTIVE<=1, cnt<=HOLD_CYCLES-1, go to HOLD.
  - Otherwise stay in IDLE with D=0.
- HOLD:
  - If VALID (retrigger, same or different SEL): D<=1<<SEL, cnt<=HOLD_CYCLES-1, stay in HOLD. The new index replaces the old one, so D stays one-hot and never shows two bits.
  - Else if cnt==0: D<=0, ACTIVE<=0, go to IDLE.
  - Else cnt<=cnt-1.
- Hold counter width is $clog2(HOLD_CYCLES+1) bits. The counter never wraps.
- PENDING:
  - Each edge: PENDING <= (CLR ? 0 : PENDING) | (VALID ? 1<<SEL : 0).
  - When CLR and VALID occur in the same cycle, the result is only the new index bit.
- EVT_CNT:
  - Each edge: EVT_CNT <= (CLR ? 0 : EVT_CNT) + (VALID ? 1 : 0), saturating at 255.
  - When CLR and VALID occur in the same cycle, the result is 1.
  - At 255 with VALID and no CLR, the value stays 255.
- CLR has no effect on D, ACTIVE or the hold state.
- ACTIVE equals |D at all times. It is registered, not derived combinationally.

## Timing
- Latency is 1 cycle: VALID sampled at edge k makes D, PENDING and EVT_CNT visible after edge k.
- A single isolated VALID pulse keeps D high for exactly HOLD_CYCLES cycles (edges k+1 .. k+HOLD_CYCLES, cleared at edge k+HOLD_CYCLES).
- With HOLD_CYCLES=1, D is a 1-cycle registered copy of the decoded input.
- Continuous VALID keeps D high indefinitely. D follows SEL with 1-cycle latency. D falls HOLD_CYCLES cycles after the last VALID.
- There are no combinational paths from any input to any output.

## Test plan
- Reset: hold RESET_N=0 for 2 edges while driving VALID=1, SEL=5 -> D=0, ACTIVE=0, PENDING=0, EVT_CNT=0. Release -> D=8'h20 one edge later.
- Single event, HOLD_CYCLES=4: SEL=3 with a 1-cycle VALID -> D=8'h08 for exactly 4 cycles then 0. PENDING=8'h08, EVT_CNT=1, ACTIVE tracks D.
- Retrigger: VALID SEL=2 at cycle 0, then VALID SEL=6 at cycle 2 -> D=8'h04 for 2 cycles, then 8'h40 for 4 cycles, never two bits set. PENDING=8'h44, EVT_CNT=2.
- Simultaneous CLR and VALID: PENDING=8'h81, EVT_CNT=7, then CLR=1 with VALID=1 and SEL=1 -> PENDING=8'h02, EVT_CNT=1. D=8'h02 is unaffected by CLR.
- Saturation: 300 consecutive VALID cycles with SEL cycling 0..7 -> EVT_CNT=255 and stays there, PENDING=8'hFF, D one-hot every cycle.
- Reset mid-hold: RESET_N=0 two cycles into a hold of SEL=7 -> D=0 and state IDLE after that edge. A following VALID starts a fresh full-length hold.

Source files
------------

// File: rtl/priority_decoder_hold.sv
// priority_decoder_hold: registered 3-to-8 one-hot decoder with pulse stretching, sticky pending bits and saturating event count
module priority_decoder_hold #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sel,
  input  logic       valid,
  input  logic       clr,
  output logic [7:0] d,
  output logic       active,
  output logic [7:0] pending,
  output logic [7:0] evt_cnt
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] hit;
  always_comb hit = valid ? 8'(8'd1 << sel) : 8'd0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      d       <= '0;
      active  <= 1'b0;
      pending <= '0;
      evt_cnt <= '0;
    end else begin
      pending <= (clr ? 8'd0 : pending) | hit;
      evt_cnt <= clr ? {7'd0, valid} : evt_cnt + {7'd0, valid && evt_cnt != 8'hFF};
      // a new event always replaces the held index, keeping d one-hot
      if (valid) begin
        d      <= hit;
        active <= 1'b1;
        cnt    <= CW'(HOLD_CYCLES - 1);
        state  <= HOLD;
      end else if (state == HOLD) begin
        if (cnt == '0) begin
          d      <= '0;
          active <= 1'b0;
          state  <= IDLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule
